pst_eval_sequencer: RTL and testbench

Sequences a full piece-square evaluation pass over the 64-square board. On `start` it walks board memory square by square and decodes each piece code. It selects the matching 6-bit signed entry from the six packed piece-square tables, which are 384-bit ROM outputs, and accumulates a signed score. White entries add and black entries subtract. It sits between board RAM and the piece-square ROMs, and feeds the evaluation result to the search controller.

---
 rtl/pst_eval_sequencer.sv | 152 +++++++++++++++
 tb/tb_pst_eval_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pst_eval_sequencer.sv
// Piece-square evaluation sequencer: walks the 64 board squares, looks up each
// piece's signed 6-bit table entry and accumulates a signed score. Optional PST_MATERIAL_EN adds material values.
module pst_eval_sequencer #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [5:0]       boardAddr,
    input  logic [3:0]       boardData,
    input  logic [383:0]     pawnMap,
    input  logic [383:0]     knightMap,
    input  logic [383:0]     bishopMap,
    input  logic [383:0]     rookMap,
    input  logic [383:0]     queenMap,
    input  logic [383:0]     kingMap,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] score
);

    if (ACC_W < 14) begin : g_width_check
        $error("pst_eval_sequencer: ACC_W must be at least 14");
    end

    // Handshake: start is a level sampled only while IDLE; done is a single-cycle
    // pulse coincident with the new score, and busy covers the whole pass.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;

    logic [5:0]         data_sq;
    logic [5:0]         tbl_idx;
    logic [2:0]         ptype;
    logic               black;
    logic [383:0]       sel_map;
    logic [5:0]         entry;
    logic [ACC_W-1:0]   magnitude;
    logic [ACC_W-1:0]   contrib;
    logic [ACC_W-1:0]   acc_next;
    logic               valid_piece;

`ifdef PST_MATERIAL_EN
    logic [ACC_W-1:0]   material;
`endif

    assign ptype = boardData[2:0];
    assign black = boardData[3];

    // The data on boardData belongs to the square addressed one cycle earlier;
    // in DRAIN the address is parked at 63, which is also the square being read.
    always_comb begin
        data_sq = (state == DRAIN) ? 6'd63 : (boardAddr - 6'd1);
        tbl_idx = data_sq ^ {black, black, black, 3'b000};
    end

    always_comb begin
        sel_map     = '0;
        valid_piece = 1'b1;
        case (ptype)
            3'd1:    sel_map = pawnMap;
            3'd2:    sel_map = knightMap;
            3'd3:    sel_map = bishopMap;
            3'd4:    sel_map = rookMap;
            3'd5:    sel_map = queenMap;
            3'd6:    sel_map = kingMap;
            default: valid_piece = 1'b0;
        endcase
    end

`ifdef PST_MATERIAL_EN
    always_comb begin
        material = '0;
        case (ptype)
            3'd1:    material = ACC_W'(100);
            3'd2:    material = ACC_W'(320);
            3'd3:    material = ACC_W'(330);
            3'd4:    material = ACC_W'(500);
            3'd5:    material = ACC_W'(900);
            default: material = '0;
        endcase
    end
`endif

    always_comb begin
        entry     = sel_map[{3'b000, tbl_idx} * 9'd6 +: 6];
`ifdef PST_MATERIAL_EN
        magnitude = {{(ACC_W-6){entry[5]}}, entry} + material;
`else
        magnitude = {{(ACC_W-6){entry[5]}}, entry};
`endif
        if (!valid_piece) begin
            contrib = '0;
        end else if (black) begin
            contrib = '0 - magnitude;
        end else begin
            contrib = magnitude;
        end
        acc_next = acc + contrib;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            score     <= '0;
            boardAddr <= '0;
            acc       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        boardAddr <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // Address 0 only occurs in the first RUN cycle, before any data is valid.
                    if (boardAddr != 6'd0) begin
                        acc <= acc_next;
                    end
                    if (boardAddr == 6'd63) begin
                        state <= DRAIN;
                    end else begin
                        boardAddr <= boardAddr + 6'd1;
                    end
                end
                DRAIN: begin
                    acc   <= acc_next;
                    score <= acc_next;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pst_eval_sequencer.sv
// Self-checking bench for pst_eval_sequencer: table vectors, randomized boards
// against a square-sum model, and hand sequences for start/reset/back-to-back corners.
module tb_pst_eval_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   boardAddr;
    logic [3:0]   boardData = 4'd0;
    logic [383:0] maps [6];
    logic         busy;
    logic         done;
    logic [15:0]  score;

    logic [3:0]   board [64];
    logic [15:0]  exp_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Synchronous board RAM: data for an address appears one cycle later.
    always @(posedge clk) boardData <= board[boardAddr];

    pst_eval_sequencer #(.ACC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .boardAddr(boardAddr), .boardData(boardData),
        .pawnMap(maps[0]), .knightMap(maps[1]), .bishopMap(maps[2]),
        .rookMap(maps[3]), .queenMap(maps[4]), .kingMap(maps[5]),
        .busy(busy), .done(done), .score(score)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int material_of(input int t);
`ifdef PST_MATERIAL_EN
        case (t)
            1: return 100;
            2: return 320;
            3: return 330;
            4: return 500;
            5: return 900;
            default: return 0;
        endcase
`else
        return 0;
`endif
    endfunction

    // Reference: score = sum over squares of +/-(table entry + material), mod 2^16.
    function automatic logic [15:0] model_score();
        int total = 0;
        for (int sq = 0; sq < 64; sq++) begin
            int t = int'(board[sq][2:0]);
            int is_black = int'(board[sq][3]);
            if (t >= 1 && t <= 6) begin
                int idx = is_black ? (sq ^ 56) : sq;
                logic [383:0] m = maps[t-1];
                logic signed [5:0] e = m[idx*6 +: 6];
                int val = int'(e) + material_of(t);
                total += is_black ? -val : val;
            end
        end
        return total[15:0];
    endfunction

    task automatic clear_all();
        for (int i = 0; i < 64; i++) board[i] = 4'd0;
        for (int m = 0; m < 6; m++) maps[m] = '0;
    endtask

    // Runs one pass from a start sampled at the next edge (E0). pulse_at > 0
    // re-asserts start for the single edge E_pulse_at while the pass is busy.
    task automatic run_pass(input int pulse_at, output int lat, output logic [15:0] sc,
                            output bit busy_ok, output logic post_done, output logic post_busy);
        lat = -1;
        sc = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_ok = (busy === 1'b1) && (done === 1'b0);
        for (int k = 1; k <= 200; k++) begin
            start = (k == pulse_at);
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                sc = score;
                busy_ok = busy_ok && (busy === 1'b0);
                break;
            end
            busy_ok = busy_ok && (busy === 1'b1);
        end
        start = 1'b0;
        @(posedge clk); #1;
        post_done = done;
        post_busy = busy;
    endtask

    typedef struct {
        logic [5:0]        sq;
        logic [3:0]        code;
        logic signed [5:0] entry;
        int                exp_plain;
        int                exp_mat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int lat;
        logic [15:0] sc;
        bit busy_ok;
        logic post_done, post_busy;
        logic [15:0] exp_v;
        int done_seen;

        vecs[0] = '{6'd27, 4'd2,  6'sd10,  10,   330};   // white knight centre
        vecs[1] = '{6'd62, 4'd10, -6'sd30, 30,  -290};   // black knight, idx 6
        vecs[2] = '{6'd3,  4'd5,  6'sd0,   0,    900};   // white queen, zero table
        vecs[3] = '{6'd8,  4'd9,  6'sd31, -31,  -131};   // black pawn, idx 48
        vecs[4] = '{6'd63, 4'd6, -6'sd32, -32,  -32};    // white king on last square
        vecs[5] = '{6'd0,  4'd7,  6'sd20,  0,    0};     // reserved type
        vecs[6] = '{6'd5,  4'd0,  6'sd15,  0,    0};     // empty board
        vecs[7] = '{6'd0,  4'd12, -6'sd1,  1,   -499};   // black rook, first square

        clear_all();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_score", 32'(score), 32'd0);
        check("reset_addr", 32'(boardAddr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All-empty board: latency, busy window, single done.
        run_pass(0, lat, sc, busy_ok, post_done, post_busy);
        check("empty_latency", 32'(lat), 32'd65);
        check("empty_score", 32'(sc), 32'd0);
        check("empty_busy_window", 32'(busy_ok), 32'd1);
        check("empty_done_width", 32'(post_done), 32'd0);

        for (int v = 0; v < 8; v++) begin
            int idx;
            clear_all();
            idx = vecs[v].code[3] ? (int'(vecs[v].sq) ^ 56) : int'(vecs[v].sq);
            for (int m = 0; m < 6; m++) maps[m][idx*6 +: 6] = vecs[v].entry;
            board[vecs[v].sq] = vecs[v].code;
`ifdef PST_MATERIAL_EN
            exp_v = vecs[v].exp_mat[15:0];
`else
            exp_v = vecs[v].exp_plain[15:0];
`endif
            run_pass(0, lat, sc, busy_ok, post_done, post_busy);
            check($sformatf("vec%0d_score", v), 32'(sc), 32'(exp_v));
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'd65);
        end

        // Start position with rank-symmetric tables cancels exactly.
        clear_all();
        for (int m = 0; m < 6; m++)
            for (int i = 0; i < 32; i++) begin
                logic [5:0] r = 6'($urandom_range(0, 63));
                maps[m][i*6 +: 6] = r;
                maps[m][(i ^ 56)*6 +: 6] = r;
            end
        begin
            logic [3:0] back [8] = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
            for (int f = 0; f < 8; f++) begin
                board[f]      = back[f];
                board[8 + f]  = 4'd1;
                board[48 + f] = 4'd9;
                board[56 + f] = back[f] | 4'd8;
            end
        end
        run_pass(0, lat, sc, busy_ok, post_done, post_busy);
        check("startpos_score", 32'(sc), 32'd0);

        // Random boards and tables against the reference model.
        for (int n = 0; n < 20; n++) begin
            for (int m = 0; m < 6; m++)
                for (int i = 0; i < 64; i++) maps[m][i*6 +: 6] = 6'($urandom_range(0, 63));
            for (int i = 0; i < 64; i++)
                board[i] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            exp_q.push_back(model_score());
            run_pass(0, lat, sc, busy_ok, post_done, post_busy);
            exp_v = exp_q.pop_front();
            check($sformatf("rand%0d_score", n), 32'(sc), 32'(exp_v));
            check($sformatf("rand%0d_latency", n), 32'(lat), 32'd65);
        end

        // start pulsed at E10 of a pass is ignored.
        exp_v = model_score();
        run_pass(10, lat, sc, busy_ok, post_done, post_busy);
        check("ignore_latency", 32'(lat), 32'd65);
        check("ignore_score", 32'(sc), 32'(exp_v));
        check("ignore_busy_window", 32'(busy_ok), 32'd1);
        check("ignore_no_second_done", 32'(post_done), 32'd0);
        check("ignore_idle_after", 32'(post_busy), 32'd0);

        // Back-to-back: start held through the first done; board changes for pass 2.
        begin
            logic [15:0] exp1, exp2;
            int lat1 = -1, lat2 = -1;
            bit held_ok = 1'b1;
            exp1 = model_score();
            start = 1'b1;
            @(posedge clk); #1;
            for (int k = 1; k <= 200; k++) begin
                @(posedge clk); #1;
                if (done === 1'b1) begin lat1 = k; break; end
            end
            check("b2b_first_latency", 32'(lat1), 32'd65);
            check("b2b_first_score", 32'(score), 32'(exp1));
            @(posedge clk); #1;
            start = 1'b0;
            check("b2b_restart_busy", 32'(busy), 32'd1);
            for (int i = 0; i < 64; i++) board[i] = 4'($urandom_range(0, 15));
            exp2 = model_score();
            for (int k = 67; k <= 300; k++) begin
                @(posedge clk); #1;
                if (done === 1'b1) begin lat2 = k; break; end
                if (score !== exp1) held_ok = 1'b0;
            end
            check("b2b_second_latency", 32'(lat2), 32'd131);
            check("b2b_score_held", 32'(held_ok), 32'd1);
            check("b2b_second_score", 32'(score), 32'(exp2));
        end

        // Reset asserted at E30 of a pass.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_score", 32'(score), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_addr", 32'(boardAddr), 32'd0);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("midreset_no_done", 32'(done_seen), 32'd0);

        // A fresh pass after reset still works.
        exp_v = model_score();
        run_pass(0, lat, sc, busy_ok, post_done, post_busy);
        check("post_reset_score", 32'(sc), 32'(exp_v));
        check("post_reset_latency", 32'(lat), 32'd65);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
